// File: rtl/dmem_slave_pkg.sv
// Shared types and constants for the data-memory slave.
package dmem_slave_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_slave_if.sv
// Request/response bus between an initiator and the data-memory slave.
interface dmem_slave_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rdata_o;
    logic        err_o;

    modport slave (
        input  req_valid_i, addr_i, wdata_i, we_i, sel_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rdata_o, err_o
    );

    modport master (
        output req_valid_i, addr_i, wdata_i, we_i, sel_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_slave_sram_sp.sv
// Single-port word SRAM with registered read and per-byte write enables.
module sram_sp #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Array write / registered read; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_slave.sv
// Data-memory slave: request capture, wait-state FSM, range check, response hold.
module dmem_slave
    import dmem_slave_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_slave_if.slave  bus
);

    localparam int                    AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [31:0]           DEPTH_L   = 32'(DEPTH_WORDS);

    state_t                state_r, state_s;
    logic [WAIT_CNT_W-1:0] cnt_r, cnt_s;
    logic [AW-1:0]         addr_r;
    logic [31:0]           wdata_r;
    logic                  we_r;
    logic [3:0]            sel_r;
    logic                  in_range_r;
    logic                  rsp_valid_r;
    logic                  err_r;
    logic                  rd_ok_r;
    logic                  req_hs_s;
    logic                  rsp_hs_s;
    logic                  access_s;
    logic [31:0]           sram_rdata_s;

    // Next-state, counter and strobe logic; WAIT is always visited at least once
    // so the array is driven only from the capture registers.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        req_hs_s = 1'b0;
        rsp_hs_s = 1'b0;
        access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid_i) begin
                    req_hs_s = 1'b1;
                    state_s  = WAIT;
                    cnt_s    = WAIT_INIT;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
                    access_s = 1'b1;
                    state_s  = RESP;
                end else begin
                    cnt_s    = cnt_r - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_hs_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s  = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {WAIT_CNT_W{1'b0}};
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {WAIT_CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture with the range check folded in at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {AW{1'b0}};
            wdata_r    <= 32'h0000_0000;
            we_r       <= 1'b0;
            sel_r      <= 4'b0000;
            in_range_r <= 1'b0;
        end else if (req_hs_s) begin
            addr_r     <= bus.addr_i[AW+1:2];
            wdata_r    <= bus.wdata_i;
            we_r       <= bus.we_i;
            sel_r      <= bus.sel_i;
            in_range_r <= ((bus.addr_i >> 2) < DEPTH_L);
        end
    end

    // Response flags, set on RESP entry and cleared by the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            rd_ok_r     <= 1'b0;
        end else if (access_s) begin
            rsp_valid_r <= 1'b1;
            err_r       <= ~in_range_r;
            rd_ok_r     <= ~we_r & in_range_r;
        end else if (rsp_hs_s) begin
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            rd_ok_r     <= 1'b0;
        end
    end

    sram_sp #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (access_s & in_range_r),
        .we    (we_r),
        .be    (sel_r),
        .addr  (addr_r),
        .wdata (wdata_r),
        .rdata (sram_rdata_s)
    );

    assign bus.req_ready_o = (state_r == IDLE);
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.err_o       = err_r;
    assign bus.rdata_o     = rd_ok_r ? sram_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_slave.sv
// Directed self-checking bench for dmem_slave at WAIT_CYCLES 1, 0 and 15.
module tb_dmem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid_w0, req_valid_w15, rsp_ready, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmem_slave_if bus1 ();
    dmem_slave_if bus0 ();
    dmem_slave_if bus15 ();

    assign bus1.req_valid_i  = req_valid;
    assign bus1.addr_i       = addr;
    assign bus1.wdata_i      = wdata;
    assign bus1.we_i         = we;
    assign bus1.sel_i        = sel;
    assign bus1.rsp_ready_i  = rsp_ready;
    assign bus0.req_valid_i  = req_valid_w0;
    assign bus0.addr_i       = addr;
    assign bus0.wdata_i      = wdata;
    assign bus0.we_i         = we;
    assign bus0.sel_i        = sel;
    assign bus0.rsp_ready_i  = rsp_ready;
    assign bus15.req_valid_i = req_valid_w15;
    assign bus15.addr_i      = addr;
    assign bus15.wdata_i     = wdata;
    assign bus15.we_i        = we;
    assign bus15.sel_i       = sel;
    assign bus15.rsp_ready_i = rsp_ready;

    dmem_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dmem_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0))  u_dut0  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, act, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=1 instance; lat = edges after the request handshake.
    task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(posedge clk); #1;
        check({tag, ".ready"}, 32'(bus1.req_ready_o), 32'd1);
        req_valid = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!bus1.rsp_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},   32'(lat), 32'd2);
        check({tag, ".rdata"}, bus1.rdata_o, exp_rd);
        check({tag, ".err"},   32'(bus1.err_o), 32'(exp_err));
    endtask

    task automatic lat_probe(input int which, output int lat);
        @(posedge clk); #1;
        we = 1'b0; addr = 32'h0000_0000;
        if (which == 0) req_valid_w0 = 1'b1;
        else            req_valid_w15 = 1'b1;
        @(posedge clk); #1;
        req_valid_w0 = 1'b0; req_valid_w15 = 1'b0;
        lat = 0;
        while (!((which == 0) ? bus0.rsp_valid_o : bus15.rsp_valid_o) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; req_valid = 1'b0; req_valid_w0 = 1'b0; req_valid_w15 = 1'b0;
        rsp_ready = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 32'(bus1.rsp_valid_o), 32'd0);
        check("rst.rdata", bus1.rdata_o, 32'h0);
        check("rst.err",   32'(bus1.err_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.ready", 32'(bus1.req_ready_o), 32'd1);

        // Full-word write/read, byte-lane merge, empty sel, ignored low address bits.
        xact("wr100",  1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        xact("rd100",  1'b0, 32'h100, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0);
        xact("wr104",  1'b1, 32'h104, 32'h1122_3344, 4'b1111, 32'h0, 1'b0);
        xact("wr104b", 1'b1, 32'h104, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0);
        xact("rd104",  1'b0, 32'h104, 32'h0,         4'b0000, 32'h1122_AB44, 1'b0);
        xact("wr104z", 1'b1, 32'h104, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        xact("rd107",  1'b0, 32'h107, 32'h0,         4'b0000, 32'h1122_AB44, 1'b0);

        // Out-of-range access aliases word 0 in the index bits, so word 0 must survive.
        xact("wr0",    1'b1, 32'h0,    32'hA5A5_A5A5, 4'b1111, 32'h0, 1'b0);
        xact("rdoor",  1'b0, 32'h4000, 32'h0,         4'b0000, 32'h0, 1'b1);
        xact("wroor",  1'b1, 32'h4000, 32'h1234_5678, 4'b1111, 32'h0, 1'b1);
        xact("rd0",    1'b0, 32'h0,    32'h0,         4'b0000, 32'hA5A5_A5A5, 1'b0);

        // Back-pressure with a new request held pending behind the response.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; we = 1'b0; addr = 32'h100;
        @(posedge clk); #1;
        addr = 32'h104;
        lat = 0;
        while (!bus1.rsp_valid_o && lat < 40) begin
            check("bp.ready_wait", 32'(bus1.req_ready_o), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("bp.lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", 32'(bus1.rsp_valid_o), 32'd1);
            check("bp.rdata", bus1.rdata_o, 32'hDEAD_BEEF);
            check("bp.err",   32'(bus1.err_o), 32'd0);
            check("bp.ready", 32'(bus1.req_ready_o), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.valid_drop", 32'(bus1.rsp_valid_o), 32'd0);
        check("bp.ready_idle", 32'(bus1.req_ready_o), 32'd1);
        @(posedge clk); #1;
        check("bp.accepted", 32'(bus1.req_ready_o), 32'd0);
        req_valid = 1'b0;
        lat = 0;
        while (!bus1.rsp_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp.pend_lat",   32'(lat), 32'd2);
        check("bp.pend_rdata", bus1.rdata_o, 32'h1122_AB44);

        // Latency at the wait-count extremes.
        lat_probe(0, lat);
        check("w0.lat", 32'(lat), 32'd1);
        check("w0.err", 32'(bus0.err_o), 32'd0);
        lat_probe(15, lat);
        check("w15.lat", 32'(lat), 32'd16);
        check("w15.err", 32'(bus15.err_o), 32'd0);

        // Reset during WAIT of a write must drop it.
        xact("wr200", 1'b1, 32'h200, 32'h0000_0055, 4'b1111, 32'h0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; we = 1'b1; addr = 32'h200; wdata = 32'h0000_00AA; sel = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(bus1.rsp_valid_o), 32'd0);
        check("ar.rdata", bus1.rdata_o, 32'h0);
        check("ar.err",   32'(bus1.err_o), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("ar.valid_hold", 32'(bus1.rsp_valid_o), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar.ready", 32'(bus1.req_ready_o), 32'd1);
        xact("rd200", 1'b0, 32'h200, 32'h0, 4'b0000, 32'h0000_0055, 1'b0);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
